// File: rtl/int_ctrl_pkg.sv
// rtl/int_ctrl_pkg.sv - shared register offsets, FSM encoding and codes for int_ctrl
//
// Purpose : constants shared by int_ctrl and int_prio_enc.
// Contents: register byte offsets, FSM state encoding, "no interrupt" code,
//           decoded register-operation bundle type.
package int_ctrl_pkg;

  // Register byte offsets
  localparam logic [7:0] REG_ENABLE  = 8'h0;
  localparam logic [7:0] REG_PENDING = 8'h4;
  localparam logic [7:0] REG_CLAIM   = 8'h8;
  localparam logic [7:0] REG_TRIGGER = 8'hC;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQ     = 2'd1;
  localparam logic [1:0] ST_SERVICE = 2'd2;

  // Request code meaning "no interrupt"; real codes are source index + 1
  localparam logic [7:0] CODE_NONE = 8'd0;

  // Decoded register operations for one cycle
  typedef struct packed {
    logic wr_enable;
    logic wr_pending;
    logic wr_trigger;
    logic claim;
    logic complete;
  } reg_ops_t;

endpackage

// File: rtl/int_prio_enc.sv
// rtl/int_prio_enc.sv - fixed-priority encoder, lowest index wins
//
// Purpose : combinational NUM_SRC-to-code encoder; code = index + 1.
// Ports   : i_req   [NUM_SRC] request vector (pending & enable)
//           o_code  [8]       winning code, CODE_NONE when no request
//           o_valid           any request present
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] i_req,
  output logic [7:0]         o_code,
  output logic               o_valid
);

  // Scan from the top down so the lowest set index is the last to assign.
  always_comb begin
    o_code  = CODE_NONE;
    o_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_code  = 8'(i + 1);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - interrupt controller with claim/complete handshake
//
// Purpose : synchronizes NUM_SRC peripheral requests, keeps pending/enable
//           state, arbitrates by fixed priority and forwards one request at a
//           time to the CSR file via an IDLE/REQ/SERVICE handshake.
// Config  : define INT_CTRL_EDGE_EN to enable the RW trigger-type register
//           (0xC) and per-source edge detection; otherwise all sources are
//           level-triggered and 0xC reads 0.
// Ports   : clk                 core clock, rising edge
//           rst                 asynchronous active-low reset
//           irq_src [NUM_SRC]   raw requests, asynchronous to clk
//           reg_addr [ADDR_W]   register byte offset
//           reg_wdata [32]      write data
//           reg_we / reg_re     single-cycle write / read strobes
//           reg_rdata [32]      registered read data, valid cycle after reg_re
//           peripheral_int      interrupt request to the CSR file
//           peripheral_int_code request code (index + 1), 0 = none
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ADDR_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [ADDR_W-1:0]  reg_addr,
  input  logic [31:0]        reg_wdata,
  input  logic               reg_we,
  input  logic               reg_re,
  output logic [31:0]        reg_rdata,
  output logic               peripheral_int,
  output logic [7:0]         peripheral_int_code
);

  logic [NUM_SRC-1:0] r_sync1;
  logic [NUM_SRC-1:0] r_sync2;
  logic [NUM_SRC-1:0] r_en;
  logic [NUM_SRC-1:0] r_pend;
  logic [1:0]         r_state;
  logic               r_int;
  logic [7:0]         r_code;
  logic [7:0]         r_is_code;
  logic [31:0]        r_rdata;

  logic [NUM_SRC-1:0] w_trig;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_is_mask;
  logic [NUM_SRC-1:0] w_claim_mask;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [7:0]         w_win_code;
  logic               w_win_valid;
  logic [31:0]        w_rd_nxt;
  reg_ops_t           w_ops;
  logic               w_unused;

  // Only the low bits of write data carry meaning.
  assign w_unused = ^reg_wdata;

  always_comb begin
    w_ops            = '0;
    w_ops.wr_enable  = reg_we && (reg_addr == ADDR_W'(REG_ENABLE));
    w_ops.wr_pending = reg_we && (reg_addr == ADDR_W'(REG_PENDING));
    w_ops.wr_trigger = reg_we && (reg_addr == ADDR_W'(REG_TRIGGER));
    // Claim only has an effect while a request is being offered.
    w_ops.claim      = reg_re && (reg_addr == ADDR_W'(REG_CLAIM)) && (r_state == ST_REQ);
    // Complete must name the in-service code; anything else is dropped.
    w_ops.complete   = reg_we && (reg_addr == ADDR_W'(REG_CLAIM)) && (r_state == ST_SERVICE)
                       && (reg_wdata[7:0] == r_is_code);
  end

`ifdef INT_CTRL_EDGE_EN
  logic [NUM_SRC-1:0] r_trig;
  logic [NUM_SRC-1:0] r_sync_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_trig   <= '0;
      r_sync_d <= '0;
    end else begin
      r_sync_d <= r_sync2;
      if (w_ops.wr_trigger) r_trig <= reg_wdata[NUM_SRC-1:0];
    end
  end

  assign w_trig = r_trig;
  assign w_rise = r_sync2 & ~r_sync_d;
`else
  assign w_trig = '0;
  assign w_rise = '0;
`endif

  // One-hot views of the in-service code and of the code being claimed.
  always_comb begin
    w_is_mask    = '0;
    w_claim_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_is_mask[i]    = (r_is_code == 8'(i + 1));
      w_claim_mask[i] = (r_code == 8'(i + 1));
    end
  end

  // In-service sources are masked so they cannot re-pend before completion;
  // a claim clears its bit even if the source is re-sampled high that edge.
  always_comb begin
    w_pend_nxt = r_pend;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_trig[i]) begin
        if (w_rise[i] && !w_is_mask[i])        w_pend_nxt[i] = 1'b1;
        if (w_ops.wr_pending && reg_wdata[i])  w_pend_nxt[i] = 1'b0;
      end else begin
        w_pend_nxt[i] = r_sync2[i] & ~w_is_mask[i];
      end
      if (w_ops.claim && w_claim_mask[i]) w_pend_nxt[i] = 1'b0;
    end
  end

  int_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .i_req   (r_pend & r_en),
    .o_code  (w_win_code),
    .o_valid (w_win_valid)
  );

  // Read mux sees pre-write register values, so a same-cycle write/read
  // returns the old contents.
  always_comb begin
    w_rd_nxt = '0;
    if (reg_addr == ADDR_W'(REG_ENABLE))       w_rd_nxt = 32'(r_en);
    else if (reg_addr == ADDR_W'(REG_PENDING)) w_rd_nxt = 32'(r_pend);
    else if (reg_addr == ADDR_W'(REG_CLAIM))   w_rd_nxt = (r_state == ST_REQ) ? 32'(r_code) : 32'd0;
    else if (reg_addr == ADDR_W'(REG_TRIGGER)) w_rd_nxt = 32'(w_trig);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_en    <= '0;
      r_pend  <= '0;
      r_rdata <= '0;
    end else begin
      r_sync1 <= irq_src;
      r_sync2 <= r_sync1;
      r_pend  <= w_pend_nxt;
      if (w_ops.wr_enable) r_en <= reg_wdata[NUM_SRC-1:0];
      if (reg_re) r_rdata <= w_rd_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_int     <= 1'b0;
      r_code    <= CODE_NONE;
      r_is_code <= CODE_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_state <= ST_REQ;
            r_int   <= 1'b1;
            r_code  <= w_win_code;
          end
        end
        ST_REQ: begin
          if (w_ops.claim) begin
            r_state   <= ST_SERVICE;
            r_int     <= 1'b0;
            r_code    <= CODE_NONE;
            r_is_code <= r_code;
          end else if (w_win_valid) begin
            r_code <= w_win_code;
          end else begin
            r_state <= ST_IDLE;
            r_int   <= 1'b0;
            r_code  <= CODE_NONE;
          end
        end
        ST_SERVICE: begin
          if (w_ops.complete) begin
            r_state   <= ST_IDLE;
            r_is_code <= CODE_NONE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_int     <= 1'b0;
          r_code    <= CODE_NONE;
          r_is_code <= CODE_NONE;
        end
      endcase
    end
  end

  assign reg_rdata           = r_rdata;
  assign peripheral_int      = r_int;
  assign peripheral_int_code = r_code;

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - self-checking bench for int_ctrl
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [31:0] reg_rdata;
  logic        peripheral_int;
  logic [7:0]  peripheral_int_code;

  int n_checks = 0;
  int n_fail   = 0;

  int_ctrl #(.NUM_SRC(8), .ADDR_W(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .irq_src             (irq_src),
    .reg_addr            (reg_addr),
    .reg_wdata           (reg_wdata),
    .reg_we              (reg_we),
    .reg_re              (reg_re),
    .reg_rdata           (reg_rdata),
    .peripheral_int      (peripheral_int),
    .peripheral_int_code (peripheral_int_code)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_we = 1'b1;
    tick(1);
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    reg_addr = a; reg_re = 1'b1;
    tick(1);
    reg_re = 1'b0;
    d = reg_rdata;
  endtask

  // Reference rule: lowest set index wins, code is index + 1, 0 for none.
  function automatic int lowest_code(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i + 1;
    return 0;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0; irq_src = '0; reg_addr = '0; reg_wdata = '0; reg_we = 1'b0; reg_re = 1'b0;
    tick(3);
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %0b expected 0", peripheral_int); end
    n_checks++; if (peripheral_int_code !== 8'd0) begin n_fail++; $display("FAIL reset_code: got %0d expected 0", peripheral_int_code); end
    n_checks++; if (reg_rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %0h expected 0", reg_rdata); end
    rst = 1'b1;
    tick(1);
    rd(4'h0, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_enable: got %0h expected 0", d); end
    rd(4'h4, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_pending: got %0h expected 0", d); end
    rd(4'hC, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_trigger: got %0h expected 0", d); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    wr(4'h0, 32'h05);
    irq_src = 8'h04;
    tick(3);
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL basic_early_int: got %0b expected 0", peripheral_int); end
    tick(1);
    n_checks++; if (peripheral_int !== 1'b1) begin n_fail++; $display("FAIL basic_int: got %0b expected 1", peripheral_int); end
    n_checks++; if (peripheral_int_code !== 8'd3) begin n_fail++; $display("FAIL basic_code: got %0d expected 3", peripheral_int_code); end
    rd(4'h8, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL basic_claim: got %0d expected 3", d); end
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL basic_int_drop: got %0b expected 0", peripheral_int); end
    irq_src = '0;
    tick(4);
    wr(4'h8, 32'd3);
    tick(3);
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %0b expected 0", peripheral_int); end
  endtask

  task automatic test_priority();
    logic [31:0] d;
    wr(4'h0, 32'hFF);
    irq_src = 8'h05;
    tick(5);
    n_checks++; if (peripheral_int_code !== 8'd1) begin n_fail++; $display("FAIL prio_code: got %0d expected 1", peripheral_int_code); end
    rd(4'h8, d);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL prio_claim: got %0d expected 1", d); end
    irq_src = 8'h04;
    tick(4);
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL prio_held: got %0b expected 0", peripheral_int); end
    wr(4'h8, 32'd1);
    tick(1);
    n_checks++; if (peripheral_int !== 1'b1 || peripheral_int_code !== 8'd3) begin
      n_fail++; $display("FAIL prio_next: got int=%0b code=%0d expected int=1 code=3", peripheral_int, peripheral_int_code); end
    rd(4'h8, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL prio_claim2: got %0d expected 3", d); end
    irq_src = '0;
    tick(4);
    wr(4'h8, 32'd3);
    tick(3);
  endtask

  task automatic test_complete_mismatch();
    logic [31:0] d;
    irq_src = 8'h04;
    tick(5);
    rd(4'h8, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL cmpl_claim: got %0d expected 3", d); end
    wr(4'h8, 32'd2);
    tick(4);
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL cmpl_bad_ignored: got int=%0b expected 0", peripheral_int); end
    rd(4'h8, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL cmpl_service_claim: got %0d expected 0", d); end
    wr(4'h8, 32'd3);
    tick(2);
    n_checks++; if (peripheral_int !== 1'b1 || peripheral_int_code !== 8'd3) begin
      n_fail++; $display("FAIL cmpl_good: got int=%0b code=%0d expected int=1 code=3", peripheral_int, peripheral_int_code); end
    rd(4'h8, d);
    irq_src = '0;
    tick(4);
    wr(4'h8, 32'd3);
    tick(3);
  endtask

  task automatic test_claim_race();
    logic [31:0] d;
    irq_src = 8'h02;
    tick(5);
    n_checks++; if (peripheral_int_code !== 8'd2) begin n_fail++; $display("FAIL race_code: got %0d expected 2", peripheral_int_code); end
    irq_src = '0;
    tick(2);
    rd(4'h8, d);
    n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL race_claim: got %0d expected 2", d); end
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL race_int: got %0b expected 0", peripheral_int); end
    tick(3);
    wr(4'h8, 32'd2);
    tick(3);
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL race_idle: got %0b expected 0", peripheral_int); end
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] d;
    reg_addr = 4'h0; reg_wdata = 32'h3C; reg_we = 1'b1; reg_re = 1'b1;
    tick(1);
    reg_we = 1'b0; reg_re = 1'b0;
    n_checks++; if (reg_rdata !== 32'hFF) begin n_fail++; $display("FAIL rw_old: got %0h expected ff", reg_rdata); end
    rd(4'h0, d);
    n_checks++; if (d !== 32'h3C) begin n_fail++; $display("FAIL rw_new: got %0h expected 3c", d); end
    wr(4'h0, 32'hFF);
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(4'hE, 32'hFFFF_FFFF);
    rd(4'hE, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_e: got %0h expected 0", d); end
    rd(4'h2, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_2: got %0h expected 0", d); end
    rd(4'h0, d);
    n_checks++; if (d !== 32'hFF) begin n_fail++; $display("FAIL unmapped_enable: got %0h expected ff", d); end
  endtask

  task automatic test_trigger();
    logic [31:0] d;
`ifdef INT_CTRL_EDGE_EN
    wr(4'hC, 32'h02);
    rd(4'hC, d);
    n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL trig_rw: got %0h expected 2", d); end
    wr(4'h0, 32'h02);
    irq_src = 8'h02;
    tick(1);
    irq_src = '0;
    tick(6);
    rd(4'h4, d);
    n_checks++; if (d !== 32'h02) begin n_fail++; $display("FAIL trig_pend_held: got %0h expected 2", d); end
    n_checks++; if (peripheral_int !== 1'b1 || peripheral_int_code !== 8'd2) begin
      n_fail++; $display("FAIL trig_int: got int=%0b code=%0d expected int=1 code=2", peripheral_int, peripheral_int_code); end
    wr(4'h4, 32'h02);
    tick(1);
    n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL trig_w1c_int: got %0b expected 0", peripheral_int); end
    rd(4'h4, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL trig_w1c_pend: got %0h expected 0", d); end
    wr(4'hC, 32'h00);
    wr(4'h0, 32'hFF);
`else
    wr(4'hC, 32'hFF);
    rd(4'hC, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL trig_disabled: got %0h expected 0", d); end
    irq_src = 8'h08;
    tick(5);
    wr(4'h4, 32'h08);
    rd(4'h4, d);
    n_checks++; if (d !== 32'h08) begin n_fail++; $display("FAIL level_no_w1c: got %0h expected 8", d); end
    n_checks++; if (peripheral_int_code !== 8'd4) begin n_fail++; $display("FAIL level_code: got %0d expected 4", peripheral_int_code); end
    rd(4'h8, d);
    irq_src = '0;
    tick(4);
    wr(4'h8, 32'd4);
    tick(3);
`endif
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [7:0]  src, en, act;
    int          exp_code;
    for (int it = 0; it < 20; it++) begin
      src = 8'($urandom);
      en  = (it == 0) ? 8'h00 : 8'($urandom);
      wr(4'h0, {24'h0, en});
      irq_src = src;
      tick(5);
      act = src & en;
      exp_code = lowest_code(act);
      rd(4'h4, d);
      n_checks++; if (d !== {24'h0, src}) begin n_fail++; $display("FAIL rnd_pending[%0d]: got %0h expected %0h", it, d, src); end
      n_checks++; if (peripheral_int !== (act != 0) || peripheral_int_code !== 8'(exp_code)) begin
        n_fail++; $display("FAIL rnd_req[%0d]: got int=%0b code=%0d expected int=%0b code=%0d", it, peripheral_int, peripheral_int_code, act != 0, exp_code); end
      rd(4'h8, d);
      n_checks++; if (d !== 32'(exp_code)) begin n_fail++; $display("FAIL rnd_claim[%0d]: got %0d expected %0d", it, d, exp_code); end
      if (exp_code != 0) begin
        n_checks++; if (peripheral_int !== 1'b0) begin n_fail++; $display("FAIL rnd_drop[%0d]: got %0b expected 0", it, peripheral_int); end
        rd(4'h4, d);
        n_checks++; if (d !== 32'(src & ~(8'd1 << (exp_code - 1)))) begin
          n_fail++; $display("FAIL rnd_pend_after[%0d]: got %0h expected %0h", it, d, src & ~(8'd1 << (exp_code - 1))); end
      end
      irq_src = '0;
      tick(4);
      if (exp_code != 0) wr(4'h8, 32'(exp_code));
      tick(3);
      n_checks++; if (peripheral_int !== 1'b0 || peripheral_int_code !== 8'd0) begin
        n_fail++; $display("FAIL rnd_idle[%0d]: got int=%0b code=%0d expected 0 0", it, peripheral_int, peripheral_int_code); end
    end
    wr(4'h0, 32'hFF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    irq_src = 8'h10;
    tick(5);
    n_checks++; if (peripheral_int !== 1'b1 || peripheral_int_code !== 8'd5) begin
      n_fail++; $display("FAIL rstmid_pre: got int=%0b code=%0d expected 1 5", peripheral_int, peripheral_int_code); end
    #1 rst = 1'b0;
    #1;
    n_checks++; if (peripheral_int !== 1'b0 || peripheral_int_code !== 8'd0) begin
      n_fail++; $display("FAIL rstmid_async: got int=%0b code=%0d expected 0 0", peripheral_int, peripheral_int_code); end
    tick(1);
    rst = 1'b1;
    rd(4'h0, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rstmid_enable: got %0h expected 0", d); end
    tick(3);
    rd(4'h4, d);
    n_checks++; if (d !== 32'h10) begin n_fail++; $display("FAIL rstmid_repend: got %0h expected 10", d); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_complete_mismatch();
    test_claim_race();
    test_rw_same_cycle();
    test_unmapped();
    test_trigger();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
